// File: rtl/mem_arbiter.sv
// Three-way arbiter in front of a single-port memory: picks one requester per
// round (round-robin or fixed priority, with a loader lock) and runs a 3-cycle access.
module mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr_in,
  input  logic [3*DATA_W-1:0] wdata_in,
  input  logic                lock,
  output logic [2:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_w_en,
  output logic [DATA_W-1:0]   mem_d_in,
  input  logic [DATA_W-1:0]   mem_d_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          last_gnt;
  logic [1:0]          winner;
  logic                win_valid;
  logic [ADDR_W-1:0]   gnt_addr, sel_addr;
  logic [DATA_W-1:0]   gnt_wdata, sel_wdata;
  logic                gnt_we, sel_we;

  // Winner selection. The loader keeps the memory while it holds lock, but only
  // once it has already won a round on its own.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/case leaves it unassigned and infers a latch.
    winner    = last_gnt;
    win_valid = |req;
    if (lock && last_gnt == 2'd2 && req[2]) begin
      winner = 2'd2;
    end else if (FIXED_PRIO) begin
      if (req[0])      winner = 2'd0;
      else if (req[1]) winner = 2'd1;
      else if (req[2]) winner = 2'd2;
    end else begin
      case (last_gnt)
        2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
        2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (winner == i[1:0]) begin
        sel_addr  = addr_in[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_in[i*DATA_W +: DATA_W];
        sel_we    = we[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (win_valid) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_ACK;
      S_ACK:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_gnt  <= 2'd2;
      gnt_addr  <= '0;
      gnt_wdata <= '0;
      gnt_we    <= 1'b0;
      ack       <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      ack   <= '0;
      if (state == S_IDLE && win_valid) begin
        last_gnt  <= winner;
        gnt_addr  <= sel_addr;
        gnt_wdata <= sel_wdata;
        gnt_we    <= sel_we;
      end
      if (state == S_ACCESS) begin
        rdata <= mem_d_out;
        ack   <= 3'b001 << last_gnt;
      end
    end
  end

  // Write enable is decoded from state, so an async reset drops it at once.
  assign mem_w_en = (state == S_ACCESS) && gnt_we;
  assign busy     = (state != S_IDLE);
  assign mem_addr = gnt_addr;
  assign mem_d_in = gnt_wdata;

endmodule
